// File: rtl/sound_pkg.sv
// Shared constants for the sound event sequencer: note prescales, event indices,
// FSM states and the per-event melody table.
package sound_pkg;

  localparam int unsigned NumEvents = 6;
  localparam int unsigned MaxNotes  = 4;
  localparam int unsigned ToneW     = 10;
  localparam int unsigned EvW       = $clog2(NumEvents);
  localparam int unsigned NoteW     = $clog2(MaxNotes);

  localparam logic [ToneW-1:0] REST = 10'h000;
  localparam logic [ToneW-1:0] DO   = 10'h175;
  localparam logic [ToneW-1:0] RE   = 10'h14C;
  localparam logic [ToneW-1:0] MI   = 10'h128;
  localparam logic [ToneW-1:0] FA   = 10'h117;
  localparam logic [ToneW-1:0] SOL  = 10'h0F9;
  localparam logic [ToneW-1:0] LA   = 10'h0DD;
  localparam logic [ToneW-1:0] SI   = 10'h0C5;

  typedef enum logic [2:0] {
    EvEnter  = 3'd0,
    EvKeyX   = 3'd1,
    EvKeyY   = 3'd2,
    EvHole   = 3'd3,
    EvBorder = 3'd4,
    EvBall   = 3'd5
  } event_e;

  typedef enum logic {
    StIdle,
    StPlay
  } state_e;

  // A zero slot terminates the melody.
  localparam logic [ToneW-1:0] TONE_TABLE [NumEvents][MaxNotes] = '{
    '{DO,   MI,   SOL,  REST},
    '{RE,   REST, REST, REST},
    '{MI,   REST, REST, REST},
    '{LA,   SOL,  MI,   DO  },
    '{SI,   REST, REST, REST},
    '{FA,   FA,   REST, REST}
  };

  function automatic logic [ToneW-1:0] tone_lookup(input int unsigned ev,
                                                   input int unsigned note);
    if (ev < NumEvents && note < MaxNotes) begin
      return TONE_TABLE[EvW'(ev)][NoteW'(note)];
    end
    return REST;
  endfunction

endpackage

// File: rtl/priority_arbiter.sv
// Combinational fixed-priority arbiter: lowest set index wins, one-hot and encoded grant.
module priority_arbiter #(
  parameter int unsigned NumReq = 6,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Latches audio request strobes, arbitrates them by fixed priority and plays a short melody
// per event. Define SOUND_PREEMPT_EN to let a higher-priority event abort the current melody.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = NumEvents,
  parameter int unsigned MAX_NOTES  = MaxNotes,
  parameter int unsigned NOTE_TICKS = 3125000,
  parameter int unsigned PRESCALE_W = ToneW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_EVENTS-1:0]         audio_req,
  input  logic                          mute,
  output logic [PRESCALE_W-1:0]         preScaleValue,
  output logic                          sound_en,
  output logic                          busy,
  output logic [$clog2(NUM_EVENTS)-1:0] active_event
);

  localparam int unsigned ActW   = $clog2(NUM_EVENTS);
  localparam int unsigned IdxW   = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int unsigned TimerW = $clog2(NOTE_TICKS);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(NOTE_TICKS - 1);

  state_e                state_q, state_d;
  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic [IdxW-1:0]       note_q, note_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  sound_en_q, sound_en_d;
  logic [ActW-1:0]       active_q, active_d;

  logic [NUM_EVENTS-1:0] gnt_onehot, clear;
  logic [ActW-1:0]       gnt_idx;
  logic                  gnt_valid;
  logic                  start;
  logic [PRESCALE_W-1:0] first_tone, next_tone;

  priority_arbiter #(
    .NumReq (NUM_EVENTS),
    .IdxW   (ActW)
  ) u_arb (
    .req_i   (pending_q),
    .gnt_o   (gnt_onehot),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // Slot lookup past the last note returns zero, which also saturates the note index.
  assign first_tone = PRESCALE_W'(tone_lookup(32'(gnt_idx), 0));
  assign next_tone  = PRESCALE_W'(tone_lookup(32'(active_q), 32'(note_q) + 32'd1));

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    timer_d    = timer_q;
    prescale_d = prescale_q;
    sound_en_d = sound_en_q;
    active_d   = active_q;
    clear      = '0;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          clear = gnt_onehot;
          start = (first_tone != '0);
        end
      end
      StPlay: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TimerW'(1);
        end else if (next_tone != '0) begin
          note_d     = note_q + IdxW'(1);
          timer_d    = TimerLoad;
          prescale_d = next_tone;
        end else begin
          state_d    = StIdle;
          note_d     = '0;
          prescale_d = '0;
          sound_en_d = 1'b0;
          active_d   = '0;
        end
`ifdef SOUND_PREEMPT_EN
        // Aborted melody is dropped; the preempting one starts without a gap cycle.
        if (gnt_valid && (gnt_idx < active_q) && (first_tone != '0)) begin
          clear = gnt_onehot;
          start = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StPlay;
      note_d     = '0;
      timer_d    = TimerLoad;
      prescale_d = first_tone;
      sound_en_d = 1'b1;
      active_d   = gnt_idx;
    end

    // A new strobe on the bit being granted wins, so that event replays later.
    pending_d = (pending_q & ~clear) | audio_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      note_q     <= '0;
      timer_q    <= '0;
      prescale_q <= '0;
      sound_en_q <= 1'b0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      note_q     <= note_d;
      timer_q    <= timer_d;
      prescale_q <= prescale_d;
      sound_en_q <= sound_en_d;
      active_q   <= active_d;
    end
  end

  assign preScaleValue = prescale_q & {PRESCALE_W{~mute}};
  assign sound_en      = sound_en_q & ~mute;
  assign busy          = (state_q == StPlay);
  assign active_event  = active_q;

endmodule
